pupil_search_ctrl: RTL and testbench
====================================

# pupil_search_ctrl

Raster-scan controller for the pupil-search pipeline, with parametrised frame size, coordinate widths and correlation width, plus a runtime scan step. On each frame-done pulse it walks candidate (X,Y) positions, hands each position to the correlator with a start/done handshake, and tracks the maximum correlation and where it occurred. At scan end it publishes the best coordinates and score with a valid pulse. It sits between the frame buffer's frame-done strobe and the correlator; downstream logic consumes the result.

## Interface
- X_LAST, default 511: last X coordinate scanned (inclusive).
- Y_LAST, default 383: last Y coordinate scanned (inclusive).
- X_W, default 10: X coordinate width; must hold X_LAST+STEP max.
- Y_W, default 9: Y coordinate width.
- CORR_W, default 24: correlation score width, unsigned.
- STEP_W, default 4: scan step input width.

Ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iFrameDone  in  1  one-cycle pulse: a new frame is ready, so start a scan.
- iStep  in  STEP_W  raster step, sampled on the accepted iFrameDone; 0 is treated as 1.
- iCorrDone  in  1  one-cycle pulse from the correlator: iCorr is valid.
- iCorr  in  CORR_W  correlation score for the current oX/oY.
- oCorrStart  out  1  one-cycle pulse: the correlator must evaluate oX/oY.
- oX  out  X_W  current candidate X.
- oY  out  Y_W  current candidate Y.
- oBusy  out  1  high whenever the state is not IDLE.
- oResultValid  out  1  one-cycle pulse: the result outputs have just been updated.
- oXresult  out  X_W  X of the best score from the last completed scan.
- oYresult  out  Y_W  Y of the best score from the last completed scan.
- oBestCorr  out  CORR_W  best score from the last completed scan.
- oOverrun  out  1  one-cycle pulse: an iFrameDone arrived while not IDLE and was dropped.

## Operation
- Reset: state IDLE; every output is 0, including the internal best score, best coordinates and the first flag.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - On iFrameDone: set X=0, Y=0, latch the step (0 becomes 1), set first=1, then go to ISSUE.
- ISSUE
  - Assert oCorrStart for exactly one cycle; oX and oY are stable from this cycle until the matching iCorrDone.
  - Go to WAIT.
- WAIT
  - Stay until iCorrDone.
  - On iCorrDone, update the best if first=1 or iCorr > best. The comparison is strict, so on a tie the earliest position in raster order wins. Then clear first.
  - Advance the position, computing the sums in X_W+1 and Y_W+1 bits so they cannot wrap:
    - If X+step <= X_LAST, set X += step and go to ISSUE.
    - Otherwise, if Y+step <= Y_LAST, set X=0, Y += step and go to ISSUE.
    - Otherwise go to DONE, with the final update included.
- DONE
  - Copy the best into oXresult, oYresult and oBestCorr.
  - Pulse oResultValid and go to IDLE.
  - The result outputs hold until the next DONE.
- Position count: ceil((X_LAST+1)/s) * ceil((Y_LAST+1)/s), in raster order (X fastest).
- iCorrDone outside WAIT is ignored.
- iFrameDone in ISSUE, WAIT or DONE is dropped and oOverrun pulses on the next cycle. The scan continues unaffected.
- If every score is 0, the result is (0,0,0) and oResultValid still pulses.

## Timing
- All outputs are registered (Moore).
- iFrameDone sampled at edge n gives oBusy=1 and oCorrStart=1 in cycle n+1.
- iCorrDone sampled at edge k gives the next oCorrStart in cycle k+1, or DONE in cycle k+1 with oResultValid and the updated results visible in cycle k+1.
- oBusy falls in the cycle after DONE. The earliest new scan is accepted from IDLE, so the minimum gap between scans is one cycle.
- A correlator that returns iCorrDone in the cycle right after oCorrStart gives a 2-cycle throughput per position.
- Asserting iRST in any state, including mid-WAIT, aborts the scan. Previous results are cleared to 0, and no oResultValid is produced for the aborted scan.

## Structure
- Shared package pupil_search_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - default constants for X_LAST and Y_LAST;
  - a clog2-based width helper.
- Sub-module raster_stepper: X/Y registers with the latched step, end-of-line and end-of-frame flags, and an advance input. It is reused by later window-search blocks.
- The argmax compare and update logic stays in the top level.

## Test plan
All scenarios use X_LAST=3 and Y_LAST=2 unless stated otherwise.
- Reset: hold iRST, then release → every output is 0 and oBusy=0. No oCorrStart appears until iFrameDone.
- Step 1: the correlator model returns 5 everywhere and 100 at (2,1) → exactly 12 oCorrStart pulses in raster order, then oResultValid with (2,1,100).
- Step 2: → starts at (0,0), (2,0), (0,2), (2,2) only, 4 pulses. iStep=0 behaves exactly like step 1, with 12 pulses.
- Tie: score 50 at (1,0) and at (3,2), 10 elsewhere → result (1,0,50). All scores 0 → result (0,0,0).
- Overrun: iFrameDone pulsed during WAIT → oOverrun for 1 cycle; the position sequence and result are unchanged. Stray iCorrDone in IDLE or ISSUE is ignored.
- Reset mid-scan: assert iRST during WAIT at (1,1) → IDLE and all outputs 0. The next iFrameDone scans fully from (0,0).

Source files
------------

// File: rtl/pupil_search_pkg.sv
// Shared types and constants for the pupil-search scan controller and its raster stepper.
package pupil_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int X_LAST_DEF = 511;
  localparam int Y_LAST_DEF = 383;

  // Bits needed to hold any value in 0..max_val.
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pupil_search_ctrl_if.sv
// Frame-done / correlator handshake and result bus of the pupil-search controller.
interface pupil_search_ctrl_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int CORR_W = 24,
  parameter int STEP_W = 4
);
  logic              iFrameDone;
  logic [STEP_W-1:0] iStep;
  logic              iCorrDone;
  logic [CORR_W-1:0] iCorr;
  logic              oCorrStart;
  logic [X_W-1:0]    oX;
  logic [Y_W-1:0]    oY;
  logic              oBusy;
  logic              oResultValid;
  logic [X_W-1:0]    oXresult;
  logic [Y_W-1:0]    oYresult;
  logic [CORR_W-1:0] oBestCorr;
  logic              oOverrun;

  modport slave (
    input  iFrameDone, iStep, iCorrDone, iCorr,
    output oCorrStart, oX, oY, oBusy, oResultValid, oXresult, oYresult, oBestCorr, oOverrun
  );

  modport master (
    output iFrameDone, iStep, iCorrDone, iCorr,
    input  oCorrStart, oX, oY, oBusy, oResultValid, oXresult, oYresult, oBestCorr, oOverrun
  );
endinterface

// File: rtl/pupil_search_ctrl_raster_stepper.sv
// Raster position generator: X fastest, runtime step latched at start (0 treated as 1).
// eol: X cannot advance on this line; eof: Y cannot advance past this line.
module raster_stepper
  import pupil_search_pkg::*;
#(
  parameter int X_LAST = X_LAST_DEF,
  parameter int Y_LAST = Y_LAST_DEF,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] step_in,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              eol,
  output logic              eof
);

  localparam int STEP_MAX = (1 << STEP_W) - 1;
  // One bit wider than the coordinate, and never too narrow for last+max step.
  localparam int XS_W = (X_W + 1 > bits_for(X_LAST + STEP_MAX)) ? X_W + 1 : bits_for(X_LAST + STEP_MAX);
  localparam int YS_W = (Y_W + 1 > bits_for(Y_LAST + STEP_MAX)) ? Y_W + 1 : bits_for(Y_LAST + STEP_MAX);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [XS_W-1:0]   x_sum;
  logic [YS_W-1:0]   y_sum;

  always_comb begin
    x_sum  = XS_W'(x_q) + XS_W'(step_q);
    y_sum  = YS_W'(y_q) + YS_W'(step_q);
    eol    = (x_sum > XS_W'(X_LAST));
    eof    = (y_sum > YS_W'(Y_LAST));
    x_d    = x_q;
    y_d    = y_q;
    step_d = step_q;
    if (start) begin
      x_d    = '0;
      y_d    = '0;
      step_d = (step_in == '0) ? STEP_W'(1) : step_in;
    end else if (advance) begin
      if (!eol) begin
        x_d = X_W'(x_sum);
      end else if (!eof) begin
        x_d = '0;
        y_d = Y_W'(y_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      step_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      step_q <= step_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/pupil_search_ctrl.sv
// Raster-scan argmax controller: issues each candidate position to the correlator and
// publishes the position and score of the strongest correlation at scan end.
//
// state | meaning
// IDLE  | waiting for iFrameDone
// ISSUE | oCorrStart pulse for the current oX/oY
// WAIT  | waiting for iCorrDone, then argmax update and advance
// DONE  | oResultValid pulse with freshly updated results
module pupil_search_ctrl
  import pupil_search_pkg::*;
#(
  parameter int X_LAST = X_LAST_DEF,
  parameter int Y_LAST = Y_LAST_DEF,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int CORR_W = 24,
  parameter int STEP_W = 4
) (
  input  logic iCLK,
  input  logic iRST,
  pupil_search_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic [CORR_W-1:0] best_corr_q, best_corr_d;
  logic [X_W-1:0]    best_x_q, best_x_d;
  logic [Y_W-1:0]    best_y_q, best_y_d;
  logic [CORR_W-1:0] res_corr_q, res_corr_d;
  logic [X_W-1:0]    res_x_q, res_x_d;
  logic [Y_W-1:0]    res_y_q, res_y_d;
  logic              corr_start_q, corr_start_d;
  logic              busy_q, busy_d;
  logic              result_valid_q, result_valid_d;
  logic              overrun_q, overrun_d;

  logic           scan_start;
  logic           advance;
  logic [X_W-1:0] x_cur;
  logic [Y_W-1:0] y_cur;
  logic           eol;
  logic           eof;

  raster_stepper #(
    .X_LAST (X_LAST),
    .Y_LAST (Y_LAST),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .STEP_W (STEP_W)
  ) u_stepper (
    .clk     (iCLK),
    .rst     (iRST),
    .start   (scan_start),
    .step_in (bus.iStep),
    .advance (advance),
    .x       (x_cur),
    .y       (y_cur),
    .eol     (eol),
    .eof     (eof)
  );

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    best_corr_d = best_corr_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    res_corr_d  = res_corr_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    scan_start  = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.iFrameDone) begin
          scan_start = 1'b1;
          first_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.iCorrDone) begin
          // Strict compare keeps the earliest raster position on ties.
          if (first_q || (bus.iCorr > best_corr_q)) begin
            best_corr_d = bus.iCorr;
            best_x_d    = x_cur;
            best_y_d    = y_cur;
          end
          first_d = 1'b0;
          if (eol && eof) begin
            res_corr_d = best_corr_d;
            res_x_d    = best_x_d;
            res_y_d    = best_y_d;
            state_d    = DONE;
          end else begin
            advance = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    corr_start_d   = (state_d == ISSUE);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
    overrun_d      = bus.iFrameDone && (state_q != IDLE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q        <= IDLE;
      first_q        <= 1'b0;
      best_corr_q    <= '0;
      best_x_q       <= '0;
      best_y_q       <= '0;
      res_corr_q     <= '0;
      res_x_q        <= '0;
      res_y_q        <= '0;
      corr_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_q        <= first_d;
      best_corr_q    <= best_corr_d;
      best_x_q       <= best_x_d;
      best_y_q       <= best_y_d;
      res_corr_q     <= res_corr_d;
      res_x_q        <= res_x_d;
      res_y_q        <= res_y_d;
      corr_start_q   <= corr_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.oCorrStart   = corr_start_q;
  assign bus.oX           = x_cur;
  assign bus.oY           = y_cur;
  assign bus.oBusy        = busy_q;
  assign bus.oResultValid = result_valid_q;
  assign bus.oXresult     = res_x_q;
  assign bus.oYresult     = res_y_q;
  assign bus.oBestCorr    = res_corr_q;
  assign bus.oOverrun     = overrun_q;

endmodule

// File: tb/tb_pupil_search_ctrl.sv
// Bench for pupil_search_ctrl on a 4x3 grid: scan vectors from a table, expected
// positions queued at frame start and popped on each oCorrStart.
module tb_pupil_search_ctrl;

  localparam int X_LAST = 3;
  localparam int Y_LAST = 2;
  localparam int X_W    = 5;
  localparam int Y_W    = 5;
  localparam int CORR_W = 8;
  localparam int STEP_W = 4;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  pupil_search_ctrl_if #(.X_W(X_W), .Y_W(Y_W), .CORR_W(CORR_W), .STEP_W(STEP_W)) bus ();

  pupil_search_ctrl #(
    .X_LAST (X_LAST),
    .Y_LAST (Y_LAST),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .CORR_W (CORR_W),
    .STEP_W (STEP_W)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  // mode: 0 = 100 at (2,1) else 5; 1 = 50 at (1,0),(3,2) else 10; 2 = all 0; 3 = 10*x+y
  typedef struct {
    int step;
    int mode;
    int lat;
    int ovr;
    int exp_n;
    int ex;
    int ey;
    int ec;
  } vec_t;

  typedef struct {
    int x;
    int y;
  } pos_t;

  vec_t vecs[8];
  pos_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  function automatic int score(input int mode, input int x, input int y);
    case (mode)
      0:       return (x == 2 && y == 1) ? 100 : 5;
      1:       return ((x == 1 && y == 0) || (x == 3 && y == 2)) ? 50 : 10;
      2:       return 0;
      default: return 10 * x + y;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " oBusy"}, bus.oBusy, 0);
    chk({tag, " oCorrStart"}, bus.oCorrStart, 0);
    chk({tag, " oX"}, bus.oX, 0);
    chk({tag, " oY"}, bus.oY, 0);
    chk({tag, " oResultValid"}, bus.oResultValid, 0);
    chk({tag, " oXresult"}, bus.oXresult, 0);
    chk({tag, " oYresult"}, bus.oYresult, 0);
    chk({tag, " oBestCorr"}, bus.oBestCorr, 0);
    chk({tag, " oOverrun"}, bus.oOverrun, 0);
  endtask

  task automatic run_scan(input int idx, input bit abort);
    vec_t v;
    pos_t p;
    int   s, cyc, cnt, px, py, n_st, ovr_seen;
    bit   done, abort_arm;
    v = vecs[idx];
    s = (v.step == 0) ? 1 : v.step;
    exp_q.delete();
    for (int y = 0; y <= Y_LAST; y += s)
      for (int x = 0; x <= X_LAST; x += s)
        exp_q.push_back('{x, y});
    @(negedge iCLK);
    bus.iFrameDone = 1'b1;
    bus.iStep      = STEP_W'(v.step);
    cyc = 0; cnt = 0; px = 0; py = 0; n_st = 0; ovr_seen = 0;
    done = 1'b0; abort_arm = 1'b0;
    while (!done && cyc < 500) begin
      @(negedge iCLK);
      cyc++;
      bus.iFrameDone = 1'b0;
      bus.iCorrDone  = 1'b0;
      if (abort_arm) begin
        iRST = 1'b1;
        #1;
        check_zero("abort");
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        chk("abort idle busy", bus.oBusy, 0);
        chk("abort no result", bus.oResultValid, 0);
        exp_q.delete();
        return;
      end
      if (cyc == 1) begin
        chk("start latency busy", bus.oBusy, 1);
        chk("start latency corrstart", bus.oCorrStart, 1);
      end
      if (bus.oOverrun) ovr_seen++;
      if (v.ovr != 0 && cyc == 3) chk("overrun pulse", bus.oOverrun, 1);
      if (bus.oCorrStart) begin
        n_st++;
        if (exp_q.size() == 0) begin
          chk("extra corrstart", n_st, v.exp_n);
        end else begin
          p = exp_q.pop_front();
          chk($sformatf("v%0d pos%0d x", idx, n_st), bus.oX, p.x);
          chk($sformatf("v%0d pos%0d y", idx, n_st), bus.oY, p.y);
        end
      end
      if (bus.oResultValid) begin
        done = 1'b1;
        chk($sformatf("v%0d xresult", idx), bus.oXresult, v.ex);
        chk($sformatf("v%0d yresult", idx), bus.oYresult, v.ey);
        chk($sformatf("v%0d bestcorr", idx), bus.oBestCorr, v.ec);
        chk($sformatf("v%0d start count", idx), n_st, v.exp_n);
        chk($sformatf("v%0d scan cycles", idx), cyc, v.exp_n * (v.lat + 1) + 1);
        chk($sformatf("v%0d overrun count", idx), ovr_seen, v.ovr);
        chk($sformatf("v%0d positions left", idx), exp_q.size(), 0);
      end else begin
        chk("busy during scan", bus.oBusy, 1);
      end
      if (v.ovr != 0 && cyc == 2) bus.iFrameDone = 1'b1;
      if (cyc == 1) begin
        bus.iCorrDone = 1'b1;
        bus.iCorr     = 8'hFF;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("pos stable x", bus.oX, px);
          chk("pos stable y", bus.oY, py);
          bus.iCorrDone = 1'b1;
          bus.iCorr     = CORR_W'(score(v.mode, px, py));
        end
      end
      if (bus.oCorrStart) begin
        cnt = v.lat;
        px  = int'(bus.oX);
        py  = int'(bus.oY);
        if (abort && px == 1 && py == 1) abort_arm = 1'b1;
      end
    end
    if (!done) chk($sformatf("v%0d scan finished", idx), 0, 1);
    @(negedge iCLK);
    chk($sformatf("v%0d idle after done", idx), bus.oBusy, 0);
    chk($sformatf("v%0d single valid pulse", idx), bus.oResultValid, 0);
    chk($sformatf("v%0d result held", idx), bus.oBestCorr, v.ec);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{step: 1,  mode: 0, lat: 1, ovr: 0, exp_n: 12, ex: 2, ey: 1, ec: 100};
    vecs[1] = '{step: 2,  mode: 0, lat: 2, ovr: 0, exp_n: 4,  ex: 0, ey: 0, ec: 5};
    vecs[2] = '{step: 0,  mode: 0, lat: 1, ovr: 0, exp_n: 12, ex: 2, ey: 1, ec: 100};
    vecs[3] = '{step: 1,  mode: 1, lat: 3, ovr: 0, exp_n: 12, ex: 1, ey: 0, ec: 50};
    vecs[4] = '{step: 1,  mode: 2, lat: 1, ovr: 0, exp_n: 12, ex: 0, ey: 0, ec: 0};
    vecs[5] = '{step: 2,  mode: 3, lat: 1, ovr: 1, exp_n: 4,  ex: 2, ey: 2, ec: 22};
    vecs[6] = '{step: 15, mode: 3, lat: 2, ovr: 0, exp_n: 1,  ex: 0, ey: 0, ec: 0};
    vecs[7] = '{step: 3,  mode: 3, lat: 1, ovr: 1, exp_n: 2,  ex: 3, ey: 0, ec: 30};

    bus.iFrameDone = 1'b0;
    bus.iStep      = '0;
    bus.iCorrDone  = 1'b0;
    bus.iCorr      = '0;

    repeat (3) @(negedge iCLK);
    check_zero("in reset");
    iRST = 1'b0;
    repeat (4) begin
      @(negedge iCLK);
      chk("no start before frame", bus.oCorrStart, 0);
    end
    check_zero("after reset");

    bus.iCorrDone = 1'b1;
    bus.iCorr     = 8'hFF;
    @(negedge iCLK);
    bus.iCorrDone = 1'b0;
    @(negedge iCLK);
    chk("stray idle busy", bus.oBusy, 0);
    chk("stray idle corrstart", bus.oCorrStart, 0);
    chk("stray idle valid", bus.oResultValid, 0);

    for (int i = 0; i < 8; i++) run_scan(i, 1'b0);

    run_scan(3, 1'b1);
    run_scan(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
